// File: rtl/nios2mypio_onchip_mem_master.sv
// Memory fill/check master for an on-chip Avalon-MM memory with no waitrequest.
// A fill writes pattern (optionally incrementing) to length consecutive words;
// a check reads them back through a READ_LATENCY-deep return pipeline and
// counts mismatches. Addresses wrap silently at 2^ADDR_W.
//
// Parameters: ADDR_W word-address width, DATA_W data width, READ_LATENCY 1..4.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   start/op/base/length/pattern/incr   command, sampled with start in IDLE
//   address/byteenable/chipselect/write/writedata/readdata   Avalon-MM master
//   busy, done       status; done is a one-cycle pulse
//   err_count        mismatches of the last check, saturating
// Optional feature (macro MEM_MASTER_ERR_CAPTURE_EN): err_addr/err_valid capture
// the address of the first mismatch of the last check.
module nios2mypio_onchip_mem_master #(
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  op,
    input  logic [ADDR_W-1:0]     base,
    input  logic [ADDR_W:0]       length,
    input  logic [DATA_W-1:0]     pattern,
    input  logic                  incr,
    output logic [ADDR_W-1:0]     address,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic                  chipselect,
    output logic                  write,
    output logic [DATA_W-1:0]     writedata,
    input  logic [DATA_W-1:0]     readdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W:0]       err_count
`ifdef MEM_MASTER_ERR_CAPTURE_EN
    ,
    output logic [ADDR_W-1:0]     err_addr,
    output logic                  err_valid
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          state, state_nxt;
    logic [CNT_W-1:0]    rem, rem_nxt;
    logic [DATA_W-1:0]   exp_q, exp_nxt;
    logic                incr_q, incr_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wd_nxt;
    logic                cs_nxt, wr_nxt, busy_nxt, done_nxt;
    logic                accept, clr_err, pend;

    // Read-return pipeline: valid bit and expected word per outstanding read.
    logic [READ_LATENCY-1:0] vld;
    logic [DATA_W-1:0]       exp_pipe [READ_LATENCY];
`ifdef MEM_MASTER_ERR_CAPTURE_EN
    logic [ADDR_W-1:0]       addr_pipe [READ_LATENCY];
`endif

    logic rd_hit, mismatch;
    assign rd_hit   = vld[READ_LATENCY-1];
    assign mismatch = rd_hit && (readdata != exp_pipe[READ_LATENCY-1]);

    // Reads still in flight other than the one returning this cycle.
    always_comb begin
        pend = 1'b0;
        for (int i = 0; i < int'(READ_LATENCY) - 1; i++) begin
            pend = pend | vld[i];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus next values of the registered bus/status outputs.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        exp_nxt   = exp_q;
        incr_nxt  = incr_q;
        addr_nxt  = '0;
        wd_nxt    = '0;
        cs_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        accept    = 1'b0;
        clr_err   = 1'b0;

        case (state)
            S_IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    accept   = 1'b1;
                    busy_nxt = 1'b1;
                    incr_nxt = incr;
                    clr_err  = op || (length == '0);
                    if (length == '0) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = op ? S_ISSUE : S_FILL;
                        cs_nxt    = 1'b1;
                        wr_nxt    = ~op;
                        addr_nxt  = base;
                        wd_nxt    = op ? '0 : pattern;
                        exp_nxt   = pattern;
                        rem_nxt   = length;
                    end
                end
            end
            S_FILL, S_ISSUE: begin
                if (rem > CNT_W'(1)) begin
                    cs_nxt   = 1'b1;
                    wr_nxt   = (state == S_FILL);
                    addr_nxt = address + ADDR_W'(1);
                    exp_nxt  = exp_q + DATA_W'(incr_q);
                    wd_nxt   = (state == S_FILL) ? (exp_q + DATA_W'(incr_q)) : '0;
                    rem_nxt  = rem - CNT_W'(1);
                end else begin
                    rem_nxt = '0;
                    if (state == S_FILL) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!pend) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Registered outputs, transfer bookkeeping, read pipeline and error count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address    <= '0;
            byteenable <= '0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= '0;
            rem        <= '0;
            exp_q      <= '0;
            incr_q     <= 1'b0;
            vld        <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                exp_pipe[i] <= '0;
            end
        end else begin
            address    <= addr_nxt;
            byteenable <= cs_nxt ? '1 : '0;
            chipselect <= cs_nxt;
            write      <= wr_nxt;
            writedata  <= wd_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            rem        <= rem_nxt;
            exp_q      <= exp_nxt;
            incr_q     <= incr_nxt;

            // The read on the bus this cycle enters stage 0.
            vld[0]      <= chipselect & ~write;
            exp_pipe[0] <= exp_q;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                vld[i]      <= vld[i-1];
                exp_pipe[i] <= exp_pipe[i-1];
            end

            if (clr_err) begin
                err_count <= '0;
            end else if (mismatch && !(&err_count)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

`ifdef MEM_MASTER_ERR_CAPTURE_EN
    // First-mismatch address capture, cleared by any accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_addr  <= '0;
            err_valid <= 1'b0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                addr_pipe[i] <= '0;
            end
        end else begin
            addr_pipe[0] <= address;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                addr_pipe[i] <= addr_pipe[i-1];
            end
            if (accept) begin
                err_addr  <= '0;
                err_valid <= 1'b0;
            end else if (mismatch && !err_valid) begin
                err_addr  <= addr_pipe[READ_LATENCY-1];
                err_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nios2mypio_onchip_mem_master.sv
module tb_nios2mypio_onchip_mem_master;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;
    localparam int unsigned RL = 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   length = '0;
    logic [DW-1:0] pattern = '0;
    logic          incr = 1'b0;
    logic [AW-1:0] address;
    logic [3:0]    byteenable;
    logic          chipselect, write;
    logic [DW-1:0] writedata, readdata;
    logic          busy, done;
    logic [AW:0]   err_count;
`ifdef MEM_MASTER_ERR_CAPTURE_EN
    logic [AW-1:0] err_addr;
    logic          err_valid;
`endif

    nios2mypio_onchip_mem_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .base(base),
        .length(length), .pattern(pattern), .incr(incr), .address(address),
        .byteenable(byteenable), .chipselect(chipselect), .write(write),
        .writedata(writedata), .readdata(readdata), .busy(busy), .done(done),
        .err_count(err_count)
`ifdef MEM_MASTER_ERR_CAPTURE_EN
        , .err_addr(err_addr), .err_valid(err_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic        wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } xfer_t;

    typedef struct {
        int unsigned cyc;
        bit          chk;
        logic [AW:0] err;
        logic [AW-1:0] eaddr;
        logic        evalid;
    } done_t;

    xfer_t xq[$];
    done_t dq[$];

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned busy_lo = 1, busy_hi = 0;

    // Reference memory contents (what the target should hold) and bus memory.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_pipe [RL];
    logic          sync_en = 1'b0;
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [DW-1:0] poke_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Target memory with fixed read latency RL.
    always @(posedge clk) begin
        if (sync_en) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= ref_mem[i];
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (chipselect && write) begin
            mem[address] <= writedata;
        end
        rd_pipe[0] <= mem[address];
        for (int i = 1; i < int'(RL); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign readdata = rd_pipe[RL-1];

    // Monitor: compares every bus cycle, done pulse and busy level against the scoreboard.
    always @(negedge clk) begin
        bit    exp_x, exp_d, exp_b;
        xfer_t x;
        done_t d;
        exp_x = (xq.size() != 0) && (xq[0].cyc == cyc);
        checks++;
        if (exp_x) begin
            x = xq.pop_front();
            if (chipselect !== 1'b1 || write !== x.wr || address !== x.addr ||
                writedata !== (x.wr ? x.data : 32'h0) || byteenable !== 4'hF) begin
                errors++;
                $display("FAIL xfer cyc=%0d: got cs=%b wr=%b addr=%h wd=%h be=%h, want cs=1 wr=%b addr=%h wd=%h be=f",
                         cyc, chipselect, write, address, writedata, byteenable, x.wr, x.addr,
                         x.wr ? x.data : 32'h0);
            end
        end else if (chipselect !== 1'b0 || write !== 1'b0 || address !== '0 ||
                     writedata !== '0 || byteenable !== 4'h0) begin
            errors++;
            $display("FAIL idle_bus cyc=%0d: got cs=%b wr=%b addr=%h wd=%h be=%h, want all zero",
                     cyc, chipselect, write, address, writedata, byteenable);
        end

        exp_d = (dq.size() != 0) && (dq[0].cyc == cyc);
        checks++;
        if (done !== exp_d) begin
            errors++;
            $display("FAIL done cyc=%0d: got %b want %b", cyc, done, exp_d);
        end
        if (exp_d) begin
            d = dq.pop_front();
            done_cnt++;
            if (d.chk) begin
                checks++;
                if (err_count !== d.err) begin
                    errors++;
                    $display("FAIL err_count cyc=%0d: got %0d want %0d", cyc, err_count, d.err);
                end
            end
`ifdef MEM_MASTER_ERR_CAPTURE_EN
            checks++;
            if (err_valid !== d.evalid || (d.evalid && err_addr !== d.eaddr)) begin
                errors++;
                $display("FAIL err_capture cyc=%0d: got v=%b a=%h want v=%b a=%h",
                         cyc, err_valid, err_addr, d.evalid, d.eaddr);
            end
`endif
        end

        exp_b = (cyc >= busy_lo) && (cyc <= busy_hi);
        checks++;
        if (busy !== exp_b) begin
            errors++;
            $display("FAIL busy cyc=%0d: got %b want %b", cyc, busy, exp_b);
        end
    end

    task automatic scramble_inputs();
        op      = 1'($urandom);
        base    = AW'($urandom);
        length  = 12'($urandom_range(1, 3));
        pattern = $urandom;
        incr    = 1'($urandom);
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
        ref_mem[a] = v;
        @(negedge clk);
        poke_addr = a;
        poke_data = v;
        poke_en   = 1'b1;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    // Issue one command; the reference model derives every transfer and the done record.
    task automatic run_op(input bit o, input logic [AW-1:0] b, input int unsigned len,
                          input logic [DW-1:0] pat, input bit inc, input bit abort);
        int unsigned   t0, nx, dcyc, nerr, d0;
        logic [AW-1:0] a, first_a;
        logic [DW-1:0] e;
        xfer_t         x;
        done_t         d;
        @(negedge clk);
        start = 1'b1; op = o; base = b; length = 12'(len); pattern = pat; incr = inc;
        t0 = cyc;
        d0 = done_cnt;
        nx = abort ? 1 : len;
        nerr = 0;
        first_a = '0;
        for (int unsigned k = 0; k < nx; k++) begin
            a = AW'((b + k) % DEPTH);
            e = pat + (inc ? DW'(k) : 32'h0);
            x.cyc = t0 + 1 + k; x.wr = ~o; x.addr = a; x.data = e;
            xq.push_back(x);
            if (!o) ref_mem[a] = e;
            else if (ref_mem[a] !== e) begin
                if (nerr == 0) first_a = a;
                nerr++;
            end
        end
        if (len == 0) dcyc = t0 + 1;
        else if (o)   dcyc = t0 + len + RL + 1;
        else          dcyc = t0 + len + 1;
        if (!abort) begin
            d.cyc = dcyc; d.chk = o || (len == 0);
            d.err = (nerr > 4095) ? 12'hFFF : 12'(nerr);
            d.eaddr = first_a; d.evalid = (nerr != 0);
            dq.push_back(d);
        end
        busy_lo = t0 + 1;
        busy_hi = abort ? t0 + 1 : dcyc;
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
        if (abort) begin
            @(posedge clk);
            #1 reset = 1'b1;
            @(negedge clk);
            checks++;
            if (chipselect !== 1'b0 || busy !== 1'b0 || err_count !== '0 || done !== 1'b0) begin
                errors++;
                $display("FAIL abort: got cs=%b busy=%b err=%0d done=%b want all zero",
                         chipselect, busy, err_count, done);
            end
            repeat (3) @(negedge clk);
            reset = 1'b0;
        end else begin
            if (len >= 2 && $urandom_range(0, 1) == 1) begin
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            while (done_cnt == d0 && cyc < dcyc + 10) @(negedge clk);
            if (done_cnt == d0) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got no done by cyc %0d, want done at cyc %0d", cyc, dcyc);
                xq.delete();
                dq.delete();
            end
        end
    endtask

    logic [AW-1:0] lf_base = '0;
    int unsigned   lf_len = 0;
    logic [DW-1:0] lf_pat = '0;
    bit            lf_inc = 1'b0;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = $urandom;
        sync_en = 1'b1;
        repeat (3) @(negedge clk);
        sync_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (chipselect !== 1'b0 || write !== 1'b0 || address !== '0 || writedata !== '0 ||
            byteenable !== '0 || busy !== 1'b0 || done !== 1'b0 || err_count !== '0) begin
            errors++;
            $display("FAIL reset_state: got cs=%b wr=%b addr=%h wd=%h be=%h busy=%b done=%b err=%0d, want zero",
                     chipselect, write, address, writedata, byteenable, busy, done, err_count);
        end

        run_op(1'b0, 11'h010, 4, 32'hA5A50000, 1'b1, 1'b0);
        run_op(1'b1, 11'h010, 4, 32'hA5A50000, 1'b1, 1'b0);
        poke(11'h012, 32'hDEADBEEF);
        run_op(1'b1, 11'h010, 4, 32'hA5A50000, 1'b1, 1'b0);
        run_op(1'b0, 11'h7FE, 4, 32'h12345678, 1'b0, 1'b0);
        run_op(1'b1, 11'h7FE, 4, 32'h12345678, 1'b0, 1'b0);
        run_op(1'b0, 11'h100, 0, 32'h0, 1'b0, 1'b0);
        run_op(1'b1, 11'h100, 0, 32'h0, 1'b0, 1'b0);
        run_op(1'b0, 11'h000, 2048, 32'hC0DE0000, 1'b1, 1'b0);
        run_op(1'b1, 11'h000, 2048, 32'hC0DE0000, 1'b1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            bit            o;
            logic [AW-1:0] b;
            int unsigned   len;
            logic [DW-1:0] pat;
            bit            inc;
            o   = 1'($urandom);
            b   = AW'($urandom);
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 300) : $urandom_range(0, 12);
            pat = $urandom;
            inc = 1'($urandom);
            if (o && $urandom_range(0, 1) == 1) begin
                b = lf_base; len = lf_len; pat = lf_pat; inc = lf_inc;
            end
            if (!o) begin
                lf_base = b; lf_len = len; lf_pat = pat; lf_inc = inc;
            end
            run_op(o, b, len, pat, inc, 1'b0);
        end

        run_op(1'b0, 11'h200, 16, 32'h55AA0000, 1'b1, 1'b1);
        run_op(1'b1, 11'h200, 1, 32'h55AA0000, 1'b1, 1'b0);
        run_op(1'b1, 11'h201, 3, 32'h55AA0001, 1'b1, 1'b0);

        repeat (4) @(negedge clk);
        checks++;
        if (xq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d transfers %0d dones pending, want 0 0", xq.size(), dq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios2mypio_onchip_mem_master.md
NIOS2MYPIO_ONCHIP_MEM_MASTER -- requirements
Module: nios2mypio_onchip_mem_master

Interface
REQ-001 ADDR_W, default 11, word-address width of the target memory port.
REQ-002 DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 READ_LATENCY, default 1, cycles from read issue to valid readdata; legal range 1..4.
REQ-004 clk  in  1  single clock; all logic is on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle command strobe, sampled only in IDLE.
REQ-007 op  in  1  0 = fill (write), 1 = check (read and compare), sampled with start.
REQ-008 base  in  ADDR_W  first word address, sampled with start.
REQ-009 length  in  ADDR_W+1  number of words, 0..2^ADDR_W, sampled with start.
REQ-010 pattern  in  DATA_W  seed data, sampled with start.
REQ-011 incr  in  1  1 = expected or written word is pattern+index (mod 2^DATA_W); 0 = constant pattern; sampled with start.
REQ-012 address  out  ADDR_W  Avalon-MM master word address.
REQ-013 byteenable  out  DATA_W/8  always all ones while chipselect is high, else zero.
REQ-014 chipselect  out  1  bus transfer valid.
REQ-015 write  out  1  high with chipselect for fill transfers.
REQ-016 writedata  out  DATA_W  fill data.
REQ-017 readdata  in  DATA_W  read data, valid READ_LATENCY cycles after a read issue.
REQ-018 busy  out  1  high from the cycle after an accepted start through the done cycle.
REQ-019 done  out  1  one-cycle completion pulse.
REQ-020 err_count  out  ADDR_W+1  mismatch count of the last check, saturating at all ones.

Function
REQ-021 FSM states: IDLE, FILL, ISSUE, DRAIN, DONE; start accepted in IDLE only, ignored otherwise.
REQ-022 IDLE: start with length=0 goes to DONE directly; no bus transfer; err_count cleared.
REQ-023 Start accepted in cycle 0: first transfer in cycle 1; one transfer per cycle, no bubbles (the target has no waitrequest).
REQ-024 Transfer k (k = 0..length-1) uses address (base+k) mod 2^ADDR_W; wrap past the top address is silent.
REQ-025 FILL: chipselect=write=1 for cycles 1..length, writedata per REQ-011; then DONE.
REQ-026 ISSUE: chipselect=1, write=0 for cycles 1..length; expected word and a valid bit enter a READ_LATENCY-deep pipeline; then DRAIN until the pipeline is empty.
REQ-027 Each valid returning readdata is compared with its expected word; a mismatch increments err_count, saturating.
REQ-028 DONE lasts one cycle with done=1, then IDLE. Fill done is in cycle length+1; check done is in cycle length+READ_LATENCY+1.
REQ-029 err_count clears on an accepted check start and holds its value until the next accepted start.
REQ-030 Outputs not driving a transfer are zero: address, writedata, write, chipselect.

Reset
REQ-031 Reset clears the FSM to IDLE and sets busy, done, chipselect, write, address, writedata, byteenable and err_count to zero.
REQ-032 Reset mid-operation aborts immediately with no further transfers, no done pulse and no partial-error retention.

Configuration
REQ-033 With MEM_MASTER_ERR_CAPTURE_EN defined, the block adds output err_addr (ADDR_W) holding the address of the first mismatch of the last check, and output err_valid (1) set on that first mismatch. Both clear on an accepted start or reset.
REQ-034 Without MEM_MASTER_ERR_CAPTURE_EN, these ports and their registers do not exist; all other behaviour is identical.

Verification
REQ-035 Fill: base=0x010, length=4, pattern=0xA5A50000, incr=1 -> writes 0xA5A50000..0xA5A50003 to addresses 0x010..0x013 in cycles 1..4; done in cycle 5.
REQ-036 Check after REQ-035 with READ_LATENCY=1 and identical arguments -> 4 reads in cycles 1..4; done in cycle 6; err_count=0.
REQ-037 Check the same range with the model corrupting address 0x012 to 0xDEADBEEF -> err_count=1; with the macro defined, err_addr=0x012 and err_valid=1.
REQ-038 Wrap: base=0x7FE, length=4, fill -> addresses 0x7FE, 0x7FF, 0x000, 0x001; length=0 -> done in cycle 1 with no chipselect.
REQ-039 Start pulsed while busy is ignored; reset asserted in cycle 2 of a 16-word fill -> chipselect low immediately, no done, busy=0, err_count=0.
